lns_to_linear: RTL and testbench

Converts a signed-log (LNS) operand back to a sign-magnitude fixed-point linear value. It sits at the output boundary of the log-domain datapath, after the log adder, and delivers results to linear-domain consumers. It is the decode direction of the LNS number format: log value X maps to linear magnitude 2^X. It runs iteratively, one fraction bit per cycle, with valid/ready handshakes on both sides.

---
 rtl/lns_to_linear_pkg.sv | 33 +++
 rtl/lns_to_linear_pow2_rom.sv | 18 +
 rtl/lns_to_linear.sv | 135 +++++++++++++
 tb/tb_lns_to_linear.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lns_to_linear_pkg.sv
// Shared LNS format constants, decoder FSM states and the 2^(2^-i) constant table.
package lns_to_linear_pkg;

  localparam int LNS_LOG_W     = 22;
  localparam int LNS_FRAC_BITS = 12;
  localparam int LNS_ACC_W     = 32;
  localparam int LNS_OUT_W     = 32;
  localparam int LNS_OUT_FRAC  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_SHIFT,
    S_DONE
  } lns_state_e;

  // R[i] = round(2^(2^-i) * 2^(ACC_W-2)), unsigned Q2.30
  localparam logic [LNS_ACC_W-1:0] POW2_TAB [1:LNS_FRAC_BITS] = '{
    32'd1518500250,
    32'd1276901417,
    32'd1170923762,
    32'd1121280436,
    32'd1097253708,
    32'd1085434106,
    32'd1079572136,
    32'd1076653033,
    32'd1075196443,
    32'd1074468888,
    32'd1074105294,
    32'd1073923544
  };

endpackage

// File: rtl/lns_to_linear_pow2_rom.sv
// Combinational lookup of R[idx]; indices outside 1..FRAC_BITS return zero.
module lns_pow2_rom
  import lns_to_linear_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0]     idx,
  output logic [LNS_ACC_W-1:0] r
);

  always_comb begin
    r = '0;
    for (int k = 1; k <= LNS_FRAC_BITS; k++) begin
      if (idx == IDX_W'(k)) r = POW2_TAB[k];
    end
  end

endmodule

// File: rtl/lns_to_linear.sv
// Iterative LNS -> sign-magnitude linear decoder, one fraction bit per cycle.
//   state   | meaning
//   S_IDLE  | waiting for an operand, in_ready high
//   S_MUL   | multiply acc by R[i] for each set fraction bit, FRAC_BITS cycles
//   S_SHIFT | apply integer exponent, saturate/underflow, register result
//   S_DONE  | result held with out_valid until out_ready
module lns_to_linear
  import lns_to_linear_pkg::*;
#(
  parameter int LOG_W     = LNS_LOG_W,
  parameter int FRAC_BITS = LNS_FRAC_BITS,
  parameter int ACC_W     = LNS_ACC_W,
  parameter int OUT_W     = LNS_OUT_W,
  parameter int OUT_FRAC  = LNS_OUT_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG_W-1:0] in_log,
  input  logic             in_sign,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_mag,
  output logic             out_sign,
  output logic             out_sat
);

  localparam int IDX_W = $clog2(FRAC_BITS + 1);
  localparam int INT_W = LOG_W - FRAC_BITS;
  localparam int SH_W  = INT_W + 8;
  localparam logic [ACC_W-1:0] ACC_ONE = {2'b01, {(ACC_W-2){1'b0}}};

  lns_state_e state, state_nx;

  logic [FRAC_BITS-1:0]    frac_sr;
  logic signed [INT_W-1:0] int_q;
  logic                    sign_q, zero_q;
  logic [ACC_W-1:0]        acc, r_i, acc_mul;
  logic [2*ACC_W-1:0]      prod;
  logic [IDX_W-1:0]        idx;

  logic signed [SH_W-1:0]  n_ext, s_sh, neg_sh;
  logic [OUT_W+ACC_W-1:0]  acc_wide;
  logic [OUT_W-1:0]        shift_mag;
  logic                    shift_sat;

  lns_pow2_rom #(.IDX_W(IDX_W)) u_rom (
    .idx (idx),
    .r   (r_i)
  );

  assign prod    = {{ACC_W{1'b0}}, acc} * {{ACC_W{1'b0}}, r_i};
  assign acc_mul = ACC_W'(prod >> (ACC_W - 2));

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nx = S_MUL;
      S_MUL:   if (idx == IDX_W'(FRAC_BITS)) state_nx = S_SHIFT;
      S_SHIFT: state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Wide signed exponent math so the most negative in_log cannot wrap
  assign n_ext    = {{(SH_W-INT_W){int_q[INT_W-1]}}, int_q};
  assign s_sh     = n_ext - SH_W'(ACC_W - 2 - OUT_FRAC);
  assign neg_sh   = -s_sh;
  assign acc_wide = {{OUT_W{1'b0}}, acc};

  always_comb begin
    shift_mag = '0;
    shift_sat = 1'b0;
    if (zero_q) begin
      shift_mag = '0;
    end else if (n_ext >= SH_W'(OUT_W - OUT_FRAC)) begin
      shift_mag = '1;
      shift_sat = 1'b1;
    end else if (!s_sh[SH_W-1]) begin
      shift_mag = OUT_W'(acc_wide << s_sh);
    end else if (neg_sh < SH_W'(ACC_W)) begin
      shift_mag = OUT_W'(acc >> neg_sh);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_mag  <= '0;
      out_sign <= 1'b0;
      out_sat  <= 1'b0;
      frac_sr  <= '0;
      int_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      acc      <= ACC_ONE;
      idx      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            frac_sr <= in_log[FRAC_BITS-1:0];
            int_q   <= in_log[LOG_W-1:FRAC_BITS];
            sign_q  <= in_sign;
            zero_q  <= in_zero;
            acc     <= ACC_ONE;
            idx     <= IDX_W'(1);
          end
        end
        S_MUL: begin
          if (frac_sr[FRAC_BITS-1]) acc <= acc_mul;
          frac_sr <= frac_sr << 1;
          idx     <= idx + IDX_W'(1);
        end
        S_SHIFT: begin
          out_mag  <= shift_mag;
          out_sat  <= shift_sat;
          out_sign <= sign_q && (shift_mag != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lns_to_linear.sv
// Self-checking bench for lns_to_linear: directed boundary cases plus a random 2^X sweep.
module tb_lns_to_linear;

  localparam int LW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sign, in_zero;
  logic [LW-1:0] in_log;
  logic          out_valid, out_ready, out_sign, out_sat;
  logic [31:0]   out_mag;

  int total = 0;
  int bad   = 0;

  lns_to_linear dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_log    (in_log),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_sign  (out_sign),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
    total++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
    end
  endtask

  // Reference: linear value 2^X in Q16.16, with a small relative tolerance
  task automatic ref_pow2(input logic [LW-1:0] x, output longint lo, output longint hi);
    int  xi;
    real v, tol;
    xi  = int'($signed(x));
    v   = (2.0 ** (real'(xi) / 4096.0)) * 65536.0;
    tol = 2.0 + v / 16777216.0;
    lo  = longint'($floor(v - tol));
    hi  = longint'($ceil(v + tol));
    if (lo < 0) lo = 0;
    if (hi > 64'hFFFF_FFFF) hi = 64'hFFFF_FFFF;
  endtask

  // One full transaction; leaves the bench one cycle after the output handshake
  task automatic run_op(input logic [LW-1:0] x, input logic sg, input logic z, input int hold,
                        output logic [31:0] mag, output logic osg, output logic osat);
    int cyc;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_log   = x;
    in_sign  = sg;
    in_zero  = z;
    step();
    in_valid = 1'b0;
    in_log   = LW'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("latency", cyc, 14);
    mag  = out_mag;
    osg  = out_sign;
    osat = out_sat;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_log   = LW'($urandom);
      in_zero  = 1'b0;
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_mag", out_mag, mag);
      chk("hold_sign", out_sign, osg);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("in_ready_after_hs", in_ready, 1);
    chk("valid_after_hs", out_valid, 0);
  endtask

  task automatic op_exact(input string tag, input logic [LW-1:0] x, input logic sg, input logic z,
                          input int hold, input longint emag, input logic esg, input logic esat);
    logic [31:0] m;
    logic        s, t;
    run_op(x, sg, z, hold, m, s, t);
    chk({tag, "_mag"}, m, emag);
    chk({tag, "_sign"}, s, esg);
    chk({tag, "_sat"}, t, esat);
  endtask

  initial begin
    logic [31:0] m;
    logic        s, t;
    logic [LW-1:0] x;
    longint lo, hi;
    int     n;
    bit     seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_log    = '0;
    in_sign   = 1'b0;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_out_sign", out_sign, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    step();

    op_exact("one", LW'(0), 1'b0, 1'b0, 0, 65536, 1'b0, 1'b0);
    op_exact("eight", LW'(3 << 12), 1'b1, 1'b0, 0, 524288, 1'b1, 1'b0);
    run_op(LW'(12'h800), 1'b0, 1'b0, 0, m, s, t);
    chk_rng("sqrt2_mag", m, 92680, 92682);
    chk("sqrt2_sat", t, 0);
    op_exact("two_p15", LW'(15 << 12), 1'b0, 1'b0, 0, 64'h8000_0000, 1'b0, 1'b0);
    op_exact("two_m16", LW'(-16 * 4096), 1'b1, 1'b0, 0, 1, 1'b1, 1'b0);
    op_exact("sat16", LW'(16 << 12), 1'b1, 1'b0, 0, 64'hFFFF_FFFF, 1'b1, 1'b1);
    op_exact("sat_max", LW'(22'h1FFFFF), 1'b0, 1'b0, 0, 64'hFFFF_FFFF, 1'b0, 1'b1);
    op_exact("under17", LW'(-17 * 4096), 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    op_exact("most_neg", LW'(22'h200000), 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    op_exact("zero_bp", LW'($urandom), 1'b1, 1'b1, 5, 0, 1'b0, 1'b0);

    // Leave a nonzero result registered, then abandon an operand with reset mid-MUL
    op_exact("pre_rst", LW'(2 << 12), 1'b1, 1'b0, 0, 262144, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_log   = LW'(5 << 12);
    in_sign  = 1'b1;
    in_zero  = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    step();
    chk("midrst_out_mag", out_mag, 0);
    chk("midrst_out_sign", out_sign, 0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", seen, 0);
    op_exact("post_rst", LW'(1 << 12), 1'b0, 1'b0, 0, 131072, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      n = int'($urandom_range(28, 0)) - 13;
      x = LW'(n * 4096 + int'($urandom_range(4095, 0)));
      s = 1'($urandom);
      ref_pow2(x, lo, hi);
      run_op(x, s, 1'b0, int'($urandom_range(2, 0)), m, in_sign, t);
      chk_rng("rand_mag", m, lo, hi);
      chk("rand_sign", in_sign, s);
      chk("rand_sat", t, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
